// File: rtl/ram_ctrl_pkg.sv
// Shared constants for the burst RAM controller: state encoding and default bus widths.
package ram_ctrl_pkg;

  localparam int DATAWIDTH_DEF = 8;
  localparam int ADDRWIDTH_DEF = 10;
  localparam int LENWIDTH_DEF  = 4;
  localparam int STATE_W       = 3;

  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_WRITE    = 3'd1;
  localparam logic [STATE_W-1:0] ST_RD_ISSUE = 3'd2;
  localparam logic [STATE_W-1:0] ST_RD_WAIT  = 3'd3;
  localparam logic [STATE_W-1:0] ST_RD_HOLD  = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = ST_IDLE,
    WRITE    = ST_WRITE,
    RD_ISSUE = ST_RD_ISSUE,
    RD_WAIT  = ST_RD_WAIT,
    RD_HOLD  = ST_RD_HOLD
  } state_t;

endpackage

// File: rtl/RAM_basic.sv
// Single-port synchronous RAM: registered read, write enable, dout cleared on reset.
module RAM_basic #(
  parameter int datawidth   = 8,
  parameter int adresswidth = 10
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [adresswidth-1:0] addressline,
  input  logic [datawidth-1:0]   din,
  output logic [datawidth-1:0]   dout
);

  logic [datawidth-1:0] mem [2**adresswidth];

  always_ff @(posedge clk) begin
    if (wr_en) mem[addressline] <= din;
    if (reset) dout <= '0;
    else       dout <= mem[addressline];
  end

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst read/write initiator for RAM_basic with valid/ready request, write and read streams.
//   state    | meaning
//   IDLE     | waiting for a request, req_ready high
//   WRITE    | accepting write beats, one RAM write per accepted beat
//   RD_ISSUE | address stable, RAM registers dout at end of cycle
//   RD_WAIT  | mem_dout valid, capture into rdata
//   RD_HOLD  | rvalid pending until rready
module ram_burst_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int ADDRWIDTH = ADDRWIDTH_DEF,
  parameter int LENWIDTH  = LENWIDTH_DEF
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDRWIDTH-1:0] req_addr,
  input  logic [LENWIDTH-1:0]  req_len,
  input  logic                 wvalid,
  output logic                 wready,
  input  logic [DATAWIDTH-1:0] wdata,
  output logic                 rvalid,
  input  logic                 rready,
  output logic [DATAWIDTH-1:0] rdata,
  output logic                 rlast,
  output logic                 done,
  output logic                 mem_wr_en,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0] mem_din,
  input  logic [DATAWIDTH-1:0] mem_dout
);

  state_t               state;
  logic [ADDRWIDTH-1:0] cur_addr;
  logic [LENWIDTH-1:0]  cnt;
  logic                 last_beat;

  assign last_beat = (cnt == '0);
  assign req_ready = (state == IDLE);
  assign wready    = (state == WRITE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur_addr  <= '0;
      cnt       <= '0;
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      rvalid    <= 1'b0;
      rdata     <= '0;
      rlast     <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          mem_wr_en <= 1'b0;
          if (req_valid) begin
            cur_addr <= req_addr;
            cnt      <= req_len;
            if (req_write) begin
              state <= WRITE;
            end else begin
              state    <= RD_ISSUE;
              mem_addr <= req_addr;
            end
          end
        end
        WRITE: begin
          if (wvalid) begin
            mem_wr_en <= 1'b1;
            mem_addr  <= cur_addr;
            mem_din   <= wdata;
            cur_addr  <= cur_addr + ADDRWIDTH'(1);
            cnt       <= cnt - LENWIDTH'(1);
            if (last_beat) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end else begin
            // bubble: address is left alone so the RAM just does a harmless read
            mem_wr_en <= 1'b0;
          end
        end
        RD_ISSUE: begin
          mem_wr_en <= 1'b0;
          state     <= RD_WAIT;
        end
        RD_WAIT: begin
          rdata  <= mem_dout;
          rvalid <= 1'b1;
          rlast  <= last_beat;
          state  <= RD_HOLD;
        end
        RD_HOLD: begin
          if (rready) begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            if (last_beat) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              cur_addr <= cur_addr + ADDRWIDTH'(1);
              cnt      <= cnt - LENWIDTH'(1);
              mem_addr <= cur_addr + ADDRWIDTH'(1);
              state    <= RD_ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl driving a RAM_basic; table of bursts plus hand-written corner sequences.
module tb_ram_burst_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, req_write;
  logic [9:0] req_addr;
  logic [3:0] req_len;
  logic       wvalid, wready;
  logic [7:0] wdata;
  logic       rvalid, rready, rlast, done;
  logic [7:0] rdata;
  logic       mem_wr_en;
  logic [9:0] mem_addr;
  logic [7:0] mem_din, mem_dout;

  ram_burst_ctrl #(.DATAWIDTH(8), .ADDRWIDTH(10), .LENWIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast),
    .done(done),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  RAM_basic #(.datawidth(8), .adresswidth(10)) ram (
    .clk(clk), .reset(reset), .wr_en(mem_wr_en), .addressline(mem_addr),
    .din(mem_din), .dout(mem_dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] data;
  } wexp_t;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] data;
    logic       last;
  } rexp_t;

  typedef struct {
    bit         wr;
    logic [9:0] addr;
    int         len;
    logic [7:0] d0;
    logic [15:0] vpat;      // bit i = wvalid in write cycle i
    int         stall_beat; // -1 = never stall
    bit         poke;       // pulse a foreign request during beat 1 of a read
    int         exp_beats;  // mem_wr_en pulses (write) or read handshakes (read)
    int         exp_done;
  } vec_t;

  wexp_t      wexp[$];
  rexp_t      rexp[$];
  logic [7:0] model [1024];
  int         errors = 0;
  int         checks = 0;
  int         done_cnt = 0;
  int         wr_pulses = 0;
  int         rd_beats = 0;
  vec_t       tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // write scoreboard: every RAM write must match the oldest driven beat
  always @(negedge clk) begin
    wexp_t we;
    if (done) done_cnt++;
    if (mem_wr_en) begin
      wr_pulses++;
      if (wexp.size() == 0) begin
        chk("wr_spurious", 32'd1, 32'd0);
      end else begin
        we = wexp.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(we.addr));
        chk("wr_data", 32'(mem_din), 32'(we.data));
      end
    end
  end

  task automatic issue_req(input bit wr, input logic [9:0] a, input int len);
    int w;
    w = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_len   = 4'(len);
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready_seen", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [9:0] addr, input int len, input logic [7:0] d0,
                          input logic [15:0] vpat);
    int         beat;
    int         cyc;
    logic       v;
    wexp_t      e;
    issue_req(1'b1, addr, len);
    beat = 0;
    cyc  = 0;
    while (beat <= len && cyc < 64) begin
      v = (cyc < 16) ? vpat[cyc] : 1'b1;
      chk("wready_in_write", 32'(wready), 32'd1);
      wvalid = v;
      wdata  = d0 + 8'(beat);
      if (v) begin
        e.addr = 10'(addr + 10'(beat));
        e.data = d0 + 8'(beat);
        wexp.push_back(e);
        model[e.addr] = e.data;
      end
      @(negedge clk);
      chk("wr_en_cycle", 32'(mem_wr_en), 32'(v));
      if (v) begin
        beat++;
        chk("wr_done_timing", 32'(done), 32'(beat == len + 1));
      end
      cyc++;
    end
    wvalid = 1'b0;
    chk("wr_burst_finished", 32'(beat), 32'(len + 1));
  endtask

  task automatic do_read(input logic [9:0] addr, input int len, input int stall_beat,
                         input bit poke);
    rexp_t e;
    int    w;
    for (int b = 0; b <= len; b++) begin
      e.addr = 10'(addr + 10'(b));
      e.data = model[e.addr];
      e.last = (b == len);
      rexp.push_back(e);
    end
    rready = 1'b1;
    issue_req(1'b0, addr, len);
    for (int b = 0; b <= len; b++) begin
      w = 0;
      while (!rvalid && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (!rvalid) begin
        chk("rvalid_timeout", 32'd0, 32'd1);
        rexp.delete();
        return;
      end
      // rvalid is high in the third cycle after the handshake edge
      if (b == 0) chk("rd_latency", 32'(w), 32'd2);
      e = rexp.pop_front();
      chk("rd_addr", 32'(mem_addr), 32'(e.addr));
      chk("rdata", 32'(rdata), 32'(e.data));
      chk("rlast", 32'(rlast), 32'(e.last));
      if (poke && b == 1) begin
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 10'd500;
        req_len   = 4'd0;
        chk("busy_req_ready", 32'(req_ready), 32'd0);
      end
      if (b == stall_beat) begin
        rready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("stall_rvalid", 32'(rvalid), 32'd1);
          chk("stall_rdata", 32'(rdata), 32'(e.data));
          chk("stall_rlast", 32'(rlast), 32'(e.last));
          chk("stall_addr", 32'(mem_addr), 32'(e.addr));
        end
        rready = 1'b1;
      end
      @(negedge clk);
      req_valid = 1'b0;
      rd_beats++;
      chk("rvalid_drop", 32'(rvalid), 32'd0);
      chk("rd_done", 32'(done), 32'(b == len));
      if (poke && b == 1) chk("busy_req_ignored", 32'(wready), 32'd0);
    end
  endtask

  initial begin
    int d0c, w0, r0;

    //          wr   addr     len d0     vpat      stall poke beats done
    tbl[0]  = '{1'b1, 10'd0,    4, 8'h05, 16'hFFFF, -1, 1'b0, 5,  1};
    tbl[1]  = '{1'b0, 10'd0,    4, 8'h00, 16'hFFFF, -1, 1'b0, 5,  1};
    tbl[2]  = '{1'b1, 10'd1022, 2, 8'hA1, 16'hFFFF, -1, 1'b0, 3,  1};
    tbl[3]  = '{1'b0, 10'd1022, 2, 8'h00, 16'hFFFF, -1, 1'b0, 3,  1};
    tbl[4]  = '{1'b1, 10'd10,   2, 8'h30, 16'hFFF5, -1, 1'b0, 3,  1};
    tbl[5]  = '{1'b0, 10'd10,   2, 8'h00, 16'hFFFF,  1, 1'b0, 3,  1};
    tbl[6]  = '{1'b1, 10'd100,  5, 8'h10, 16'hFFFF, -1, 1'b0, 6,  1};
    tbl[7]  = '{1'b0, 10'd0,    4, 8'h00, 16'hFFFF, -1, 1'b1, 5,  1};
    tbl[8]  = '{1'b1, 10'd500,  0, 8'h77, 16'hFFFF, -1, 1'b0, 1,  1};
    tbl[9]  = '{1'b0, 10'd500,  0, 8'h00, 16'hFFFF, -1, 1'b0, 1,  1};
    tbl[10] = '{1'b1, 10'd1020, 15, 8'h40, 16'hFFFF, -1, 1'b0, 16, 1};
    tbl[11] = '{1'b0, 10'd1020, 15, 8'h00, 16'hFFFF,  7, 1'b0, 16, 1};

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wvalid = 1'b0; wdata = '0; rready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_din", 32'(mem_din), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_rlast", 32'(rlast), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_wready", 32'(wready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      d0c = done_cnt; w0 = wr_pulses; r0 = rd_beats;
      if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].len, tbl[i].d0, tbl[i].vpat);
      else           do_read(tbl[i].addr, tbl[i].len, tbl[i].stall_beat, tbl[i].poke);
      #1;
      chk("op_done_count", 32'(done_cnt - d0c), 32'(tbl[i].exp_done));
      chk("op_beats", tbl[i].wr ? 32'(wr_pulses - w0) : 32'(rd_beats - r0),
          32'(tbl[i].exp_beats));
    end

    // reset two beats into a six-beat write over 100..105; beats 3..6 must never land
    d0c = done_cnt;
    issue_req(1'b1, 10'd100, 5);
    for (int k = 0; k < 2; k++) begin
      wexp_t e;
      wvalid = 1'b1;
      wdata  = 8'hE0 + 8'(k);
      e.addr = 10'(100 + k);
      e.data = wdata;
      wexp.push_back(e);
      model[e.addr] = e.data;
      @(negedge clk);
      chk("abort_wr_en", 32'(mem_wr_en), 32'd1);
    end
    reset  = 1'b1;
    wvalid = 1'b0;
    @(negedge clk);
    chk("abort_wr_en_off", 32'(mem_wr_en), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    reset = 1'b0;
    wvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_quiet", 32'(mem_wr_en), 32'd0);
      chk("abort_idle", 32'(req_ready), 32'd1);
    end
    wvalid = 1'b0;
    #1;
    chk("abort_no_done", 32'(done_cnt - d0c), 32'd0);
    do_read(10'd100, 5, -1, 1'b0);

    repeat (4) @(negedge clk);
    chk("wexp_empty", 32'(wexp.size()), 32'd0);
    chk("rexp_empty", 32'(rexp.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_burst_ctrl.md
Name: ram_burst_ctrl

Overview:
Initiator-side controller for the team's single-port synchronous RAM (RAM_basic: registered read, write-enable port, dout cleared on reset). It accepts burst read/write requests from a client over valid/ready handshakes. It sequences the RAM's wr_en, address and din lines. Read data returns to the client on a valid/ready stream with backpressure. It sits between a client (DMA/test engine) and one RAM instance.

Parameters:
DATAWIDTH, 8, data bus width; must match the RAM datawidth
ADDRWIDTH, 10, address width; must match the RAM adresswidth
LENWIDTH, 4, burst length field width; burst beats = req_len+1 (1..16 at default)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller idle, request accepted when req_valid&&req_ready
req_write  in  1  1=write burst, 0=read burst
req_addr  in  ADDRWIDTH  burst start address
req_len  in  LENWIDTH  beats minus one
wvalid  in  1  write beat present
wready  out  1  write beat accepted when wvalid&&wready
wdata  in  DATAWIDTH  write beat data
rvalid  out  1  read beat present
rready  in  1  client accepts read beat
rdata  out  DATAWIDTH  read beat data
rlast  out  1  final read beat of burst (qualified by rvalid)
done  out  1  one-cycle pulse when a burst completes
mem_wr_en  out  1  to RAM wr_en
mem_addr  out  ADDRWIDTH  to RAM addressline
mem_din  out  DATAWIDTH  to RAM din
mem_dout  in  DATAWIDTH  from RAM dout

Behaviour:
- Reset (sync, active-high): state IDLE. mem_wr_en, mem_addr, mem_din, rvalid, rdata, rlast and done are all 0. Beat counter and current address are cleared. Reset mid-burst aborts immediately: no further mem_wr_en after the reset edge, and partial data is not rolled back.
- All mem_* outputs, rdata, rvalid, rlast and done are registered. req_ready = (state==IDLE). wready = (state==WRITE).
- States: IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_HOLD.
- IDLE: on req_valid, latch cur_addr=req_addr and cnt=req_len, then go to WRITE if req_write, else RD_ISSUE. For a read, mem_addr<=req_addr and mem_wr_en<=0 at the same edge. A req_valid arriving while busy is not accepted and is held by the client.
- WRITE: on wvalid, mem_wr_en<=1, mem_addr<=cur_addr, mem_din<=wdata, cur_addr++ and cnt--. If no wvalid, mem_wr_en<=0 (bubble; the RAM performs a harmless read). When cnt==0 and the beat is accepted: go to IDLE and pulse done<=1 on the same edge as the last mem_wr_en. mem_wr_en drops to 0 on the next edge.
- RD_ISSUE: mem_wr_en=0 and mem_addr=cur_addr are stable, so the RAM registers dout at the end of this cycle. Go to RD_WAIT.
- RD_WAIT: mem_dout is valid. Set rdata<=mem_dout, rvalid<=1 and rlast<=(cnt==0), then go to RD_HOLD.
- RD_HOLD: rvalid, rdata and rlast are held stable until rready. On rready: rvalid<=0 and rlast<=0. If this was the last beat, go to IDLE with done<=1. Otherwise cur_addr++, cnt--, mem_addr<=cur_addr+1, and go to RD_ISSUE.
- Read latency: first rvalid appears 3 cycles after the request handshake edge. Steady state is one beat per 3 cycles with rready held high.
- Address arithmetic is modulo 2**ADDRWIDTH: 1023+1 wraps to 0 with no error flag. cnt is an unsigned LENWIDTH counter.
- mem_addr is held constant outside active beats, so RAM dout is never disturbed while rvalid is pending.
- A write burst followed immediately by a read of the same address returns the new data. The last write lands at the end of its mem_wr_en cycle, before RD_ISSUE.

Decomposition:
- Shared package ram_ctrl_pkg holds:
  - state encoding localparams (IDLE=0, WRITE=1, RD_ISSUE=2, RD_WAIT=3, RD_HOLD=4), 3-bit state width
  - default DATAWIDTH/ADDRWIDTH/LENWIDTH constants
- No sub-module. The address/beat counter stays inline.
- The bench instantiates ram_burst_ctrl connected to one RAM_basic with matching parameters.

Test Plan:
- Write burst addr 0, len 4, wdata 5,6,7,8,9 (wvalid held) -> mem_wr_en high 5 consecutive cycles at addresses 0..4, done pulses once. Then read burst addr 0, len 4 -> rdata 5,6,7,8,9, rlast only with 9, first rvalid 3 cycles after handshake.
- Wrap: write 3 beats at addr 1022 (data 0xA1,0xA2,0xA3), read back from 1022 -> mem_addr sequence 1022,1023,0 and data 0xA1,0xA2,0xA3.
- Write with wvalid toggling 1,0,1,0,1 for len 2 -> exactly 3 mem_wr_en pulses, with gaps matching the bubbles. Addresses are contiguous and done follows the third beat.
- Read with rready held low for 4 cycles on beat 2 -> rdata/rvalid/rlast/mem_addr stable throughout. Burst then completes with correct data.
- Assert reset for 1 cycle after 2 accepted beats of a 6-beat write -> mem_wr_en=0 from the next cycle, req_ready=1 after reset, addresses 2..5 unwritten (read returns prior contents).
- req_valid pulsed during an active read burst -> req_ready=0 and the request is ignored. Re-present after done -> accepted in IDLE.
